// File: rtl/sad_pkg.sv
// sad_pkg: shared widths and helper functions for the streaming SAD engine
package sad_pkg;
  localparam int BLK_IDX_W = 16;
  function automatic int lsum_w(int width, int lanes);
    return width + $clog2(lanes);
  endfunction
  function automatic int sad_w(int width, int lanes, int beats);
    return width + $clog2(lanes * beats);
  endfunction
endpackage

// File: rtl/sad_lane_sum.sv
// sad_lane_sum: per-lane |ori-can| followed by a balanced adder tree (combinational)
module sad_lane_sum import sad_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int LANES = 32
) (
  input  logic [LANES*WIDTH-1:0]         ori_i,
  input  logic [LANES*WIDTH-1:0]         can_i,
  output logic [lsum_w(WIDTH,LANES)-1:0] sum_o
);
  localparam int LW = lsum_w(WIDTH, LANES);
  localparam int LG = $clog2(LANES);
  for (genvar l = 0; l <= LG; l++) begin : lv
    logic [LW-1:0] s [LANES>>l];
    for (genvar i = 0; i < (LANES >> l); i++) begin : n
      if (l == 0) begin : lf
        logic [WIDTH-1:0] a, b;
        assign a = ori_i[i*WIDTH +: WIDTH];
        assign b = can_i[i*WIDTH +: WIDTH];
        assign s[i] = LW'(a > b ? a - b : b - a);
      end else begin : la
        assign s[i] = lv[l-1].s[2*i] + lv[l-1].s[2*i+1];
      end
    end
  end
  assign sum_o = lv[LG].s[0];
endmodule

// File: rtl/sad_stream_acc.sv
// sad_stream_acc: pipelined streaming SAD accumulator; optional min tracker under SAD_MIN_TRACK_EN
module sad_stream_acc import sad_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int LANES = 32,
  parameter int BEATS = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*WIDTH-1:0]              in_ori,
  input  logic [LANES*WIDTH-1:0]              in_can,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [sad_w(WIDTH,LANES,BEATS)-1:0] out_sad,
  output logic [BLK_IDX_W-1:0]                blk_idx
`ifdef SAD_MIN_TRACK_EN
  ,
  input  logic                                min_clr,
  output logic [sad_w(WIDTH,LANES,BEATS)-1:0] min_sad,
  output logic [BLK_IDX_W-1:0]                min_idx
`endif
);
  localparam int SW = sad_w(WIDTH, LANES, BEATS);
  localparam int LW = lsum_w(WIDTH, LANES);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic                   stall, acc_beat, last_beat;
  logic [CW-1:0]          cnt_q;
  logic                   v1_q, first1_q, last1_q;
  logic [LANES*WIDTH-1:0] ori1_q, can1_q;
  logic                   v2_q, first2_q, last2_q;
  logic [LW-1:0]          lsum, sum2_q;
  logic                   done_q;
  logic [SW-1:0]          acc_q, acc_d, out_sad_q;
  logic                   out_valid_q;
  logic [BLK_IDX_W-1:0]   blk_idx_q;
  assign stall     = out_valid_q && !out_ready;
  assign in_ready  = !rst && !stall;
  assign acc_beat  = in_valid && in_ready;
  assign last_beat = cnt_q == CW'(BEATS - 1);
  assign acc_d     = first2_q ? SW'(sum2_q) : acc_q + SW'(sum2_q);
  assign out_valid = out_valid_q;
  assign out_sad   = out_sad_q;
  assign blk_idx   = blk_idx_q;
  // S1: register accepted beat and track its position within the block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      ori1_q   <= '0;
      can1_q   <= '0;
    end else if (!stall) begin
      v1_q <= acc_beat;
      if (acc_beat) begin
        ori1_q   <= in_ori;
        can1_q   <= in_can;
        first1_q <= cnt_q == '0;
        last1_q  <= last_beat;
        cnt_q    <= last_beat ? '0 : cnt_q + CW'(1);
      end
    end
  end
  sad_lane_sum #(.WIDTH(WIDTH), .LANES(LANES)) u_lane_sum (
    .ori_i (ori1_q),
    .can_i (can1_q),
    .sum_o (lsum)
  );
  // S2: register the per-beat lane sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q     <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
      sum2_q   <= '0;
    end else if (!stall) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum2_q   <= lsum;
        first2_q <= first1_q;
        last2_q  <= last1_q;
      end
    end
  end
  // S3: accumulate beats; a first beat restarts the sum so no explicit clear is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      done_q <= 1'b0;
    end else if (!stall) begin
      done_q <= v2_q && last2_q;
      if (v2_q) acc_q <= acc_d;
    end
  end
  // Output stage: present block SAD, hold while stalled, count handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sad_q   <= '0;
      blk_idx_q   <= '0;
    end else begin
      out_valid_q <= stall || done_q;
      if (!stall && done_q) out_sad_q <= acc_q;
      if (out_valid_q && out_ready) blk_idx_q <= blk_idx_q + 1'b1;
    end
  end
`ifdef SAD_MIN_TRACK_EN
  logic [SW-1:0]        min_sad_q;
  logic [BLK_IDX_W-1:0] min_idx_q;
  assign min_sad = min_sad_q;
  assign min_idx = min_idx_q;
  // Min tracker: strict less-than keeps the earliest block on ties; clear beats update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_sad_q <= '1;
      min_idx_q <= '0;
    end else if (min_clr) begin
      min_sad_q <= '1;
      min_idx_q <= '0;
    end else if (out_valid_q && out_ready && out_sad_q < min_sad_q) begin
      min_sad_q <= out_sad_q;
      min_idx_q <= blk_idx_q;
    end
  end
`endif
endmodule
